alu_const_gen: RTL and testbench

Parametrised, pipelined constant-operand generator for the ALU B-input path. Produces the fixed operands the datapath needs (unit increment, RST vectors, bit masks for BIT/SET/RES, high-byte mask, DAA correction) from an encoded request instead of one-hot selects. Sits between the decoder/sequencer and the ALU input mux. Results are delivered over a two-stage valid/ready pipeline.

---
 rtl/alu_const_pkg.sv | 22 ++
 rtl/alu_const_gen_daa.sv | 16 +
 rtl/alu_const_gen.sv | 164 ++++++++++++++++
 tb/tb_alu_const_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_const_pkg.sv
// Shared definitions for the ALU constant-operand generator: request kinds,
// DAA correction constants and thresholds, RST vector stride.
package alu_const_pkg;

    typedef enum logic [2:0] {
        KIND_ZERO   = 3'd0,
        KIND_ONE    = 3'd1,
        KIND_RST    = 3'd2,
        KIND_BIT    = 3'd3,
        KIND_HIMASK = 3'd4,
        KIND_DAA    = 3'd5,
        KIND_INVBIT = 3'd6,
        KIND_RSVD   = 3'd7
    } kind_e;

    localparam logic [7:0] DAA_LO_ADJ    = 8'h06;
    localparam logic [7:0] DAA_HI_ADJ    = 8'h60;
    localparam logic [3:0] DAA_LO_THRESH = 4'd9;
    localparam logic [7:0] DAA_HI_THRESH = 8'h99;
    localparam int         RST_STRIDE    = 8;

endpackage

// File: rtl/alu_const_gen_daa.sv
// Combinational DAA correction detector: decides whether the low nibble
// and/or high nibble of the accumulator needs the 0x06 / 0x60 adjustment.
module alu_daa_detect
    import alu_const_pkg::*;
(
    input  logic [7:0] i_acc,
    input  logic       i_flag_h,
    input  logic       i_flag_c,
    output logic       o_lo,
    output logic       o_hi
);

    assign o_lo = i_flag_h || (i_acc[3:0] > DAA_LO_THRESH);
    assign o_hi = i_flag_c || (i_acc > DAA_HI_THRESH);

endmodule

// File: rtl/alu_const_gen.sv
// Pipelined constant-operand generator for the ALU B-input path.
// Stage 1 captures the request (and DAA compare bits), stage 2 holds the
// formed constant. Valid/ready on both sides, latency 2, throughput 1.
// Build option: define ALU_CONST_DAA_EN to enable the DAA kind; otherwise
// kind 5 is reported as reserved and the DAA inputs are ignored.
module alu_const_gen
    import alu_const_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_kind,
    input  logic [2:0]       in_arg,
    input  logic             in_high,
    input  logic [7:0]       in_acc,
    input  logic             in_flag_h,
    input  logic             in_flag_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_low,
    output logic             out_high,
    output logic             out_carry,
    output logic             out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] low;
        logic             carry;
        logic             err;
    } res_t;

    // Build the constant operand for one registered request.
    function automatic res_t form_const(
        input kind_e      k,
        input logic [2:0] a
`ifdef ALU_CONST_DAA_EN
        ,
        input logic       lo,
        input logic       hi
`endif
    );
        res_t r;
        r = '0;
        case (k)
            KIND_ZERO:   r.low = '0;
            KIND_ONE:    r.low = WIDTH'(1);
            KIND_RST:    r.low = WIDTH'(a) * WIDTH'(RST_STRIDE);
            KIND_BIT:    r.low = WIDTH'(1) << a;
            // Upper bytes all ones so an AND leaves them untouched.
            KIND_INVBIT: r.low = ~(WIDTH'(1) << a);
            KIND_HIMASK: begin
                if (WIDTH == 8) r.err = 1'b1;
                else            r.low = ~WIDTH'(8'hFF);
            end
            KIND_DAA: begin
`ifdef ALU_CONST_DAA_EN
                r.low   = WIDTH'((hi ? DAA_HI_ADJ : 8'h00) | (lo ? DAA_LO_ADJ : 8'h00));
                r.carry = hi;
`else
                r.err   = 1'b1;
`endif
            end
            default:     r.err = 1'b1;
        endcase
        return r;
    endfunction

    logic       r_vld_p1;
    kind_e      r_kind_p1;
    logic [2:0] r_arg_p1;
    logic       r_high_p1;

    logic             r_vld_p2;
    logic [WIDTH-1:0] r_low_p2;
    logic             r_high_p2;
    logic             r_carry_p2;
    logic             r_err_p2;

    logic w_s2_load;
    logic w_s1_adv;
    logic w_accept;
    res_t w_res;

    assign w_s2_load = !r_vld_p2 || out_ready;
    assign w_s1_adv  = r_vld_p1 && w_s2_load;
    assign in_ready  = !rst && (!r_vld_p1 || w_s1_adv);
    assign w_accept  = in_valid && in_ready;

`ifdef ALU_CONST_DAA_EN
    logic w_lo;
    logic w_hi;
    logic r_lo_p1;
    logic r_hi_p1;

    alu_daa_detect u_daa (
        .i_acc    (in_acc),
        .i_flag_h (in_flag_h),
        .i_flag_c (in_flag_c),
        .o_lo     (w_lo),
        .o_hi     (w_hi)
    );

    // Stage 1 DAA compare bits, captured with the request.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lo_p1 <= w_lo;
            r_hi_p1 <= w_hi;
        end
    end

    assign w_res = form_const(r_kind_p1, r_arg_p1, r_lo_p1, r_hi_p1);
`else
    logic w_unused_daa;
    assign w_unused_daa = ^{in_acc, in_flag_h, in_flag_c};
    assign w_res = form_const(r_kind_p1, r_arg_p1);
`endif

    // ---- stage 1: request capture ----
    // Stage 1 occupancy: fills on accept, drains when stage 2 takes it.
    always_ff @(posedge clk) begin
        if (rst)           r_vld_p1 <= 1'b0;
        else if (w_accept) r_vld_p1 <= 1'b1;
        else if (w_s1_adv) r_vld_p1 <= 1'b0;
    end

    // Stage 1 request fields, loaded only on acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_kind_p1 <= kind_e'(in_kind);
            r_arg_p1  <= in_arg;
            r_high_p1 <= in_high;
        end
    end

    // ---- stage 2: formed constant ----
    // Stage 2 loads when empty or consumed; holds everything under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2   <= 1'b0;
            r_low_p2   <= '0;
            r_high_p2  <= 1'b0;
            r_carry_p2 <= 1'b0;
            r_err_p2   <= 1'b0;
        end else if (w_s2_load) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_low_p2   <= w_res.low;
                r_high_p2  <= r_high_p1;
                r_carry_p2 <= w_res.carry;
                r_err_p2   <= w_res.err;
            end
        end
    end

    assign out_valid = r_vld_p2;
    assign out_low   = r_low_p2;
    assign out_high  = r_high_p2;
    assign out_carry = r_carry_p2;
    assign out_err   = r_err_p2;

endmodule

// File: tb/tb_alu_const_gen.sv
// Directed self-checking bench for alu_const_gen (WIDTH 16 and WIDTH 8 instances).
module tb_alu_const_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_kind = 3'd0;
    logic [2:0]  in_arg = 3'd0;
    logic        in_high = 1'b0;
    logic [7:0]  in_acc = 8'd0;
    logic        in_flag_h = 1'b0;
    logic        in_flag_c = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_high, out_carry, out_err;
    logic [15:0] out_low;
    logic        in_ready8, out_valid8, out_high8, out_carry8, out_err8;
    logic [7:0]  out_low8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_const_gen #(.WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_arg(in_arg), .in_high(in_high), .in_acc(in_acc),
        .in_flag_h(in_flag_h), .in_flag_c(in_flag_c), .out_valid(out_valid),
        .out_ready(out_ready), .out_low(out_low), .out_high(out_high),
        .out_carry(out_carry), .out_err(out_err)
    );

    alu_const_gen #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_kind(in_kind), .in_arg(in_arg), .in_high(in_high), .in_acc(in_acc),
        .in_flag_h(in_flag_h), .in_flag_c(in_flag_c), .out_valid(out_valid8),
        .out_ready(out_ready), .out_low(out_low8), .out_high(out_high8),
        .out_carry(out_carry8), .out_err(out_err8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request with out_ready high; checks exact 2-cycle latency and result on both widths.
    task automatic single(input string tag, input logic [2:0] kind, input logic [2:0] arg,
                          input logic [7:0] acc, input logic h, input logic c, input logic high,
                          input logic [15:0] e_low, input logic e_carry, input logic e_err,
                          input logic [7:0] e8_low, input logic e8_err);
        @(negedge clk);
        in_valid = 1'b1; in_kind = kind; in_arg = arg; in_acc = acc;
        in_flag_h = h; in_flag_c = c; in_high = high;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        check({tag, ".in_ready8"}, in_ready8, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_kind = 3'($urandom); in_arg = 3'($urandom);
        in_acc = 8'($urandom); in_high = ~high;
        @(negedge clk);
        check({tag, ".lat1_valid"}, out_valid, 1'b0);
        @(negedge clk);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".low"}, out_low, e_low);
        check({tag, ".carry"}, out_carry, e_carry);
        check({tag, ".err"}, out_err, e_err);
        check({tag, ".high"}, out_high, high);
        check({tag, ".valid8"}, out_valid8, 1'b1);
        check({tag, ".low8"}, out_low8, e8_low);
        check({tag, ".err8"}, out_err8, e8_err);
        check({tag, ".carry8"}, out_carry8, e_carry);
        check({tag, ".high8"}, out_high8, high);
    endtask

    logic [16:0] got_q[$];
    int          seen;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.valid", out_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst.in_ready", in_ready, 1'b1);
        check("post_rst.valid", out_valid, 1'b0);
        check("post_rst.low", out_low, 16'h0000);
        check("post_rst.high", out_high, 1'b0);
        check("post_rst.carry", out_carry, 1'b0);
        check("post_rst.err", out_err, 1'b0);

        single("rst7",    3'd2, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0038, 1'b0, 1'b0, 8'h38, 1'b0);
        single("invbit3", 3'd6, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 16'hFFF7, 1'b0, 1'b0, 8'hF7, 1'b0);
        single("himask",  3'd4, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b0, 8'h00, 1'b1);
        single("bit0",    3'd3, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 8'h01, 1'b0);
        single("kind7",   3'd7, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b1);
`ifdef ALU_CONST_DAA_EN
        single("daa9a",   3'd5, 3'd0, 8'h9A, 1'b0, 1'b0, 1'b0, 16'h0066, 1'b1, 1'b0, 8'h66, 1'b0);
        single("daa15h",  3'd5, 3'd0, 8'h15, 1'b1, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 8'h06, 1'b0);
        single("daa_c",   3'd5, 3'd0, 8'h12, 1'b0, 1'b1, 1'b0, 16'h0060, 1'b1, 1'b0, 8'h60, 1'b0);
`else
        single("daa9a",   3'd5, 3'd0, 8'h9A, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b1);
`endif

        // Stall: ONE, BIT 5, then kind 7 held off while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_kind = 3'd1; in_arg = 3'd0; in_high = 1'b0;
        check("stall.acc1_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_kind = 3'd3; in_arg = 3'd5;
        check("stall.acc2_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_kind = 3'd7; in_arg = 3'd0;
        for (int i = 0; i < 3; i++) begin
            check("stall.in_ready", in_ready, 1'b0);
            check("stall.valid", out_valid, 1'b1);
            check("stall.low", out_low, 16'h0001);
            @(negedge clk);
        end
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            if (out_valid) got_q.push_back({out_err, out_low});
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
        end
        check("drain.count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("drain.0", got_q[0], {1'b0, 16'h0001});
            check("drain.1", got_q[1], {1'b0, 16'h0020});
            check("drain.2", got_q[2], {1'b1, 16'h0000});
        end

        // Reset with two requests in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_kind = 3'd1; in_arg = 3'd0;
        @(posedge clk);
        @(negedge clk);
        in_kind = 3'd3; in_arg = 3'd2;
        @(posedge clk);
        @(negedge clk);
        check("flush.pre_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("flush.valid", out_valid, 1'b0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("flush.none_emitted", seen, 0);
        single("zero", 3'd0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
